// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the per-op result bundle.
// The ALU control decoder uses the same package.
package alu_pkg;
    localparam int ALU_N = 64;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SUBNE = 4'b0111;

    typedef struct packed {
        logic [ALU_N-1:0] result;
        logic             zero;
        logic             branch_taken;
        logic             illegal;
    } alu_res_t;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU: decodes alucontrol and produces result and flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = ALU_N
) (
    input  logic [3:0]   alucontrol,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output alu_res_t     res
);
    logic [N-1:0] r;
    logic         bad;

    always_comb begin
        r   = '0;
        bad = 1'b0;
        case (alucontrol)
            ALU_ADD:            r = a + b;
            ALU_SUB, ALU_SUBNE: r = a - b;
            ALU_AND:            r = a & b;
            ALU_OR:             r = a | b;
            default:            bad = 1'b1;
        endcase
    end

    always_comb begin
        res              = '0;
        res.result       = ALU_N'(r);
        res.zero         = (r == '0);
        res.illegal      = bad;
        // beq takes on equal operands, bne on unequal; illegal ops never branch
        res.branch_taken = ((alucontrol == ALU_SUB) && (r == '0)) ||
                           ((alucontrol == ALU_SUBNE) && (r != '0));
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a 2-entry in-order skid buffer toward writeback
// and a saturating illegal-op counter.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int N     = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alucontrol,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     result,
    output logic             zero,
    output logic             branch_taken,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

    occ_t     state;
    alu_res_t head, tail, res_new;
    logic     accept, pop;

    alu_core #(.N(N)) u_core (
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .res        (res_new)
    );

    // ready is a function of occupancy only; forced high while reset is held
    assign in_ready  = ~reset | (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign result       = out_valid ? head.result[N-1:0] : '0;
    assign zero         = out_valid & head.zero;
    assign branch_taken = out_valid & head.branch_taken;
    assign illegal      = out_valid & head.illegal;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= EMPTY;
            head          <= '0;
            tail          <= '0;
            illegal_count <= '0;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    head  <= res_new;
                    state <= ONE;
                end
                ONE: case ({accept, pop})
                    2'b11: head <= res_new;
                    2'b10: begin
                        tail  <= res_new;
                        state <= TWO;
                    end
                    2'b01: state <= EMPTY;
                    default: ;
                endcase
                TWO: if (pop) begin
                    head  <= tail;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
            if (accept && res_new.illegal && (illegal_count != '1))
                illegal_count <= illegal_count + CNT_W'(1);
        end
    end
endmodule
